// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external memory with one-cycle read latency.
// Holds full/empty for DEPTH cycles after reset while the memory sweeps itself clear.
module fifo_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  run;
  logic                  ptr_empty;
  logic                  ptr_full;
  logic [PtrW-1:0]       ptr_diff;
  logic                  push_acc;
  logic                  pop_acc;

  // Pointer-derived status; the wrap bit distinguishes full from empty.
  always_comb begin
    run       = (state_q == StRun);
    ptr_empty = (wptr_q == rptr_q);
    ptr_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    ptr_diff  = wptr_q - rptr_q;
    push_acc  = run & push & ~ptr_full;
    pop_acc   = run & pop & ~ptr_empty;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pop_valid_d = pop_acc;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    if (push_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
    // A new error event wins over a coincident clear.
    if (run && push && ptr_full) begin
      overflow_d = 1'b1;
    end
    if (run && pop && ptr_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    full           = run ? ptr_full : 1'b1;
    empty          = run ? ptr_empty : 1'b1;
    count          = ptr_diff;
    almost_full    = run & (ptr_diff >= PtrW'(AFULL_THRESH));
    pop_valid      = pop_valid_q;
    overflow       = overflow_q;
    underflow      = underflow_q;
    mem_write_en   = push_acc;
    mem_read_en    = pop_acc;
    mem_write_addr = wptr_q[ADDR_WIDTH-1:0];
    mem_read_addr  = rptr_q[ADDR_WIDTH-1:0];
    mem_write_data = push_data;
    pop_data       = mem_read_data;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the data word.
REQ-002 Parameter ADDR_WIDTH, default 5: memory address width; DEPTH = 2**ADDR_WIDTH (32).
REQ-003 Parameter AFULL_THRESH, default 28: count at or above which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 push  input  1  write request, sampled at clk.
REQ-007 push_data  input  DATA_WIDTH  word to write.
REQ-008 pop  input  1  read request, sampled at clk.
REQ-009 pop_data  output  DATA_WIDTH  read word, driven directly from mem_read_data.
REQ-010 pop_valid  output  1  registered; high for one cycle when pop_data carries the word of an accepted pop.
REQ-011 full, empty, almost_full  output  1 each  status flags.
REQ-012 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-013 overflow, underflow  output  1 each  sticky error flags.
REQ-014 clear_err  input  1  synchronous clear of overflow and underflow.
REQ-015 mem_write_en, mem_read_en  output  1 each  memory write and read strobes.
REQ-016 mem_write_addr, mem_read_addr  output  ADDR_WIDTH each  memory addresses.
REQ-017 mem_write_data  output  DATA_WIDTH  equals push_data.
REQ-018 mem_read_data  input  DATA_WIDTH  registered memory output, one-cycle read latency.

Function
REQ-019 FSM states: INIT and RUN; reset enters INIT.
- INIT covers the memory's post-reset clear sweep.
REQ-020 INIT counter runs DEPTH cycles after rstn deasserts, then moves to RUN; RUN is exited only by reset.
REQ-021 In INIT:
- full=1, empty=1, mem_write_en=0, mem_read_en=0.
- push/pop ignored; no error flag is set.
REQ-022 Pointers wptr and rptr are ADDR_WIDTH+1 bits.
- Low ADDR_WIDTH bits drive mem_write_addr and mem_read_addr.
- MSB is the wrap bit.
REQ-023 In RUN, flags are combinational from the pointers:
- empty = (wptr == rptr).
- full = low bits equal and wrap bits differ.
- count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
REQ-024 Push accepted iff RUN & push & !full.
- mem_write_en = accepted, combinational, same cycle.
- wptr increments at the next edge.
REQ-025 Pop accepted iff RUN & pop & !empty.
- mem_read_en = accepted, combinational, same cycle.
- rptr increments at the next edge.
- pop_valid is 1 in the following cycle.
REQ-026 Simultaneous push and pop: each is judged independently against the pre-edge flags.
- At full: pop accepted, push rejected.
- At empty: push accepted, pop rejected; no fall-through.
- Both accepted: count unchanged.
REQ-027 Pointers wrap modulo 2**(ADDR_WIDTH+1); address wraps from DEPTH-1 to 0 with no gap.
REQ-028 almost_full = (count >= AFULL_THRESH); forced 0 in INIT.
REQ-029 Rejected push in RUN while full sets overflow; rejected pop in RUN while empty sets underflow.
- Both flags stay set until clear_err or reset.
- If clear_err coincides with a new error event, the flag stays set.
REQ-030 pop_data is not registered by this block; it holds its value between pops because the memory holds read data.

Reset
REQ-031 rstn low, asynchronously:
- Pointers, INIT counter, pop_valid, overflow and underflow go to 0; state goes to INIT.
- Outputs: count=0, full=1, empty=1, almost_full=0, both mem strobes 0.
REQ-032 Reset mid-operation discards all stored words and restarts the full DEPTH-cycle INIT.
- No pop_valid for a pop in flight is produced.

Verification
REQ-033 Release rstn with push=1 and pop=1 held -> full=empty=1 for exactly 32 cycles, no mem strobes, no error flags; then empty=1, full=0.
REQ-034 Push 0x00..0x1F on consecutive cycles -> almost_full rises when count=28, full rises when count=32; a 33rd push sets overflow with count held at 32.
REQ-035 Drain 32 pops -> pop_valid one cycle after each pop, data 0x00..0x1F in order, empty after the last pop; a further pop sets underflow; clear_err clears both flags.
REQ-036 Run 40 cycles of push+pop with count held at 5 -> count stays 5, addresses wrap 31->0, data order intact.
REQ-037 Assert rstn low while count=12 and a pop is accepted -> no pop_valid follows, count=0, INIT restarts for 32 cycles.
